// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, parity convention
// and serial line levels. The receiver side uses the same parity constants.
package uart_pkg;

    // Transmitter FSM states; encodings 5..7 are unreachable and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity type select: even parity makes the total count of ones even.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serial line levels.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_parity_calc.sv
// Combinational parity generator. Even: XOR of all data bits; odd: its
// complement. The receiver compares the received bit against this value.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    // Select even or odd parity from the reduction XOR of the data.
    always_comb begin
        par_bit_o = ^data_i;
        case (par_typ_i)
            PAR_EVEN: par_bit_o = ^data_i;
            PAR_ODD:  par_bit_o = ~^data_i;
            default:  par_bit_o = ^data_i;
        endcase
    end

endmodule : uart_parity_calc

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. One serial bit per CLK cycle.
//
// Handshake: Data_Valid is a single-cycle request strobe. It is taken on a
// rising CLK edge only while the block is ready, which is in IDLE or in the
// last (STOP) cycle of a frame; at any other time it is dropped, not queued.
// Busy is high from the edge after acceptance until the frame's STOP cycle ends
// with no new request. P_DATA, PAR_EN and PAR_TYP are sampled on acceptance.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output tx_state_e             dbg_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic [DATA_WIDTH-1:0] sh_q,      sh_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;
    logic                  par_bit;

    // Parity is computed from the latched word so mid-frame input changes are ignored.
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_bit_o (par_bit)
    );

    // Next-state, latch and registered-output logic; TX_OUT/Busy are computed
    // for the state being entered so they are valid right after the edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        sh_d      = sh_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = IDLE_LEVEL;
        busy_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Data_Valid) begin
                    data_d    = P_DATA;
                    sh_d      = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    state_d   = ST_START;
                    tx_d      = START_LEVEL;
                    busy_d    = 1'b1;
                end
            end

            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
                tx_d    = sh_q[0];
                busy_d  = 1'b1;
            end

            ST_DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = STOP_LEVEL;
                    end
                end else begin
                    // Shift the next bit down; bit 1 becomes the bit on the line.
                    cnt_d = cnt_q + 1'b1;
                    sh_d  = sh_q >> 1;
                    tx_d  = sh_q[1];
                end
            end

            ST_PARITY: begin
                state_d = ST_STOP;
                tx_d    = STOP_LEVEL;
                busy_d  = 1'b1;
            end

            ST_STOP: begin
                if (Data_Valid) begin
                    // Back-to-back frame: no idle gap, Busy stays high.
                    data_d    = P_DATA;
                    sh_d      = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    state_d   = ST_START;
                    tx_d      = START_LEVEL;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    tx_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            sh_q      <= sh_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT    = tx_q;
    assign Busy      = busy_q;
    assign dbg_state = state_q;

endmodule : uart_tx_frame

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter that serializes one data word per frame: start bit, data bits LSB first, optional even/odd parity bit, and one stop bit. It is the transmit-side counterpart of the receiver's parity-checking path, and uses the same parity convention. It runs on the TX clock at one bit per clock; baud division happens upstream. A system controller feeds it through a single-cycle valid strobe and watches a busy flag.

Parameters:
DATA_WIDTH, 8, width of the payload word (supported range 5..9).

Ports:
CLK  input  1  transmit bit clock; one serial bit per cycle.
RST  input  1  reset; asynchronous, active-low.
P_DATA  input  DATA_WIDTH  word to transmit; sampled only on accept.
Data_Valid  input  1  request strobe; accepted only when the block is ready.
PAR_EN  input  1  1 = insert parity bit; sampled on accept.
PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
TX_OUT  output  1  serial line; idles high.
Busy  output  1  high while a frame is in flight.

Behaviour:
- Reset (RST low, asynchronous):
  - FSM goes to IDLE; TX_OUT=1, Busy=0; bit counter and data/config latches cleared.
  - Reset asserted mid-frame aborts immediately; no partial bits after release.
- All outputs are registered; no combinational path from inputs to TX_OUT or Busy.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 at edge N, latch P_DATA, PAR_EN and PAR_TYP, then go to START.
- START: TX_OUT=0, Busy=1 for exactly one cycle (visible after edge N).
- DATA: DATA_WIDTH cycles. Bit i = latched data[i], visible after edge N+1+i. The counter runs 0..DATA_WIDTH-1 and does not wrap past DATA_WIDTH-1. Next state is PARITY if PAR_EN was latched as 1, otherwise STOP.
- PARITY: one cycle. The bit is the XOR of the latched data, inverted when odd parity is selected:
  - even: parity = ^data
  - odd: parity = ~^data
  - This matches the receiver's check, so a frame produced here gives par_err=0 at the receiver.
- STOP: TX_OUT=1, Busy=1 for one cycle.
  - If Data_Valid=1 at the edge ending STOP, accept the new word and go to START. This gives back-to-back frames with zero idle gap, and Busy stays 1.
  - Otherwise go to IDLE; Busy=0 after that edge.
- Latency: start bit appears 1 edge after accept.
- Frame length: 2+DATA_WIDTH cycles without parity, 3+DATA_WIDTH with parity (10 or 11 for the default width).
- Data_Valid in START, DATA or PARITY is ignored and not queued. Changes on P_DATA, PAR_EN or PAR_TYP during a frame have no effect.
- Data_Valid held high continuously starts a new frame at every STOP, so frames are sent continuously.
- Unreachable state encodings recover to IDLE with TX_OUT=1.

Decomposition:
- Shared package (uart_pkg):
  - FSM state typedef and encodings.
  - PAR_EVEN=0 and PAR_ODD=1 constants, shared with the receiver's parity checker.
  - Constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- One natural sub-module: uart_parity_calc. It is combinational and computes the parity bit from the latched data and PAR_TYP. It is instantiated here and reusable by the RX side.
- FSM, counter and shift/select logic stay in the top module.

Test Plan:
1. Reset then idle: release RST, Data_Valid=0 for 20 cycles -> TX_OUT=1, Busy=0 throughout.
2. Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid.
   - TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (11 cycles).
   - Busy high for 11 cycles, then 0.
3. Odd parity and receiver loopback: P_DATA=0xB8, PAR_EN=1, PAR_TYP=1.
   - Parity bit = 1 (four ones, odd parity).
   - The receiver's parity checker fed the same data and this bit reports par_err=0.
4. No parity, back-to-back: 0x3C then 0xFF, PAR_EN=0, second Data_Valid at the edge ending the first STOP.
   - 20 contiguous cycles: 0,0,0,1,1,1,1,0,0,1 then 0,1,1,1,1,1,1,1,1,1.
   - Busy never drops between frames.
5. Ignored request and input stability: during frame 0x0F, pulse Data_Valid with P_DATA=0xF0 and toggle PAR_TYP mid-frame.
   - The transmitted frame is unchanged.
   - No second frame follows; Busy=0 after STOP.
6. Reset mid-frame: assert RST during DATA bit 4 of 0x55.
   - TX_OUT=1 and Busy=0 immediately, asynchronously.
   - After release, the line stays idle until the next Data_Valid.
